// File: rtl/alu_issue_unit.sv
// alu_issue_unit: issues MIPS R/I-type instructions to an external combinational ALU.
// Optional feature macro OVF_TRAP_EN: suppresses writeback of overflowing ADD/ADDI/SUB.
module alu_issue_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    input  logic                  host_we,
    input  logic [REG_ADDR_W-1:0] host_waddr,
    input  logic [DATA_W-1:0]     host_wdata,
    output logic [31:0]           alu_instruction,
    output logic [DATA_W-1:0]     alu_regA,
    output logic [DATA_W-1:0]     alu_regB,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [2:0]            alu_flags,
    output logic                  done_valid,
    output logic [DATA_W-1:0]     done_result,
    output logic [2:0]            done_flags,
    input  logic [REG_ADDR_W-1:0] dbg_raddr,
    output logic [DATA_W-1:0]     dbg_rdata
`ifdef OVF_TRAP_EN
    ,
    output logic                  ovf_trap
`endif
);

    localparam int NREG = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [31:0]             r_instr;
    logic [DATA_W-1:0]       r_regs [NREG];

    logic                    w_accept;
    logic [5:0]              w_op;
    logic [REG_ADDR_W-1:0]   w_rs;
    logic [REG_ADDR_W-1:0]   w_rt;
    logic                    w_dest_en;
    logic [REG_ADDR_W-1:0]   w_dest;
    logic                    w_host_wr;
    logic                    w_wb_wr;
    logic                    w_wb_block;

    assign instr_ready = (r_state == S_IDLE) && !host_we;
    assign w_accept    = instr_valid && instr_ready;

    assign w_op = r_instr[31:26];
    assign w_rs = r_instr[21 +: REG_ADDR_W];
    assign w_rt = r_instr[16 +: REG_ADDR_W];

    // Destination select: R-type writes rd, immediate ALU ops write rt
    always_comb begin
        w_dest_en = 1'b0;
        w_dest    = r_instr[11 +: REG_ADDR_W];
        unique case (1'b1)
            (w_op == 6'b000000): begin
                w_dest_en = 1'b1;
                w_dest    = r_instr[11 +: REG_ADDR_W];
            end
            (w_op >= 6'b001000 && w_op <= 6'b001110): begin
                w_dest_en = 1'b1;
                w_dest    = r_instr[16 +: REG_ADDR_W];
            end
            default: ;
        endcase
    end

`ifdef OVF_TRAP_EN
    logic       w_trap_op;
    logic [5:0] w_funct;

    assign w_funct    = r_instr[5:0];
    assign w_trap_op  = (w_op == 6'b001000) ||
                        ((w_op == 6'b000000) &&
                         ((w_funct == 6'b100000) || (w_funct == 6'b100010)));
    assign w_wb_block = ovf_trap;

    // Trap flag raised alongside done_valid for signed-overflowing ops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_trap <= 1'b0;
        end else begin
            ovf_trap <= (r_state == S_EXEC) && w_trap_op && alu_flags[0];
        end
    end
`else
    assign w_wb_block = 1'b0;
`endif

    assign w_host_wr = (r_state == S_IDLE) && host_we &&
                       (host_waddr != '0);
    assign w_wb_wr   = (r_state == S_WB) && w_dest_en &&
                       (w_dest != '0) && !w_wb_block;

    // Register file: host preload in IDLE, result writeback at end of WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_host_wr) begin
            r_regs[host_waddr] <= host_wdata;
        end else if (w_wb_wr) begin
            r_regs[w_dest] <= done_result;
        end
    end

    assign dbg_rdata = r_regs[dbg_raddr];

    // Issue sequencer: IDLE -> READ -> EXEC -> WB, one cycle each
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_instr         <= '0;
            alu_instruction <= '0;
            alu_regA        <= '0;
            alu_regB        <= '0;
            done_valid      <= 1'b0;
            done_result     <= '0;
            done_flags      <= '0;
        end else begin
            done_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_instr <= instr;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    alu_instruction <= r_instr;
                    alu_regA        <= r_regs[w_rs];
                    alu_regB        <= r_regs[w_rt];
                    r_state         <= S_EXEC;
                end
                S_EXEC: begin
                    done_result <= alu_result;
                    done_flags  <= alu_flags;
                    done_valid  <= 1'b1;
                    r_state     <= S_WB;
                end
                S_WB: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: directed and randomized checks of alu_issue_unit
// against a register-array reference model and a behavioural ALU stub.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        host_we;
    logic [4:0]  host_waddr;
    logic [31:0] host_wdata;
    logic [31:0] alu_instruction;
    logic [31:0] alu_regA;
    logic [31:0] alu_regB;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags;
    logic        done_valid;
    logic [31:0] done_result;
    logic [2:0]  done_flags;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
`ifdef OVF_TRAP_EN
    logic        ovf_trap;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_regs [32];

    always #5 clk = ~clk;

    alu_issue_unit dut (
        .clk             (clk),
        .rst             (rst),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .host_we         (host_we),
        .host_waddr      (host_waddr),
        .host_wdata      (host_wdata),
        .alu_instruction (alu_instruction),
        .alu_regA        (alu_regA),
        .alu_regB        (alu_regB),
        .alu_result      (alu_result),
        .alu_flags       (alu_flags),
        .done_valid      (done_valid),
        .done_result     (done_result),
        .done_flags      (done_flags),
        .dbg_raddr       (dbg_raddr),
        .dbg_rdata       (dbg_rdata)
`ifdef OVF_TRAP_EN
        ,
        .ovf_trap        (ovf_trap)
`endif
    );

    // Behavioural MIPS ALU: returns {zero, negative, overflow, result}
    function automatic logic [34:0] alu_fn(input logic [31:0] ins,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] ims;
        logic [31:0] imz;
        logic [31:0] r;
        logic        ov;
        op  = ins[31:26];
        fn  = ins[5:0];
        ims = {{16{ins[15]}}, ins[15:0]};
        imz = {16'h0, ins[15:0]};
        r   = 32'h0;
        ov  = 1'b0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: begin
                        r  = a + b;
                        ov = (a[31] == b[31]) && (r[31] != a[31]);
                    end
                    6'h21: r = a + b;
                    6'h22: begin
                        r  = a - b;
                        ov = (a[31] != b[31]) && (r[31] != a[31]);
                    end
                    6'h23: r = a - b;
                    6'h24: r = a & b;
                    6'h25: r = a | b;
                    6'h26: r = a ^ b;
                    6'h27: r = ~(a | b);
                    6'h2a: r = {31'h0, $signed(a) < $signed(b)};
                    6'h2b: r = {31'h0, a < b};
                    default: r = 32'h0;
                endcase
            end
            6'h08: begin
                r  = a + ims;
                ov = (a[31] == ims[31]) && (r[31] != a[31]);
            end
            6'h09: r = a + ims;
            6'h0a: r = {31'h0, $signed(a) < $signed(ims)};
            6'h0b: r = {31'h0, a < ims};
            6'h0c: r = a & imz;
            6'h0d: r = a | imz;
            6'h0e: r = a ^ imz;
            6'h0f: r = {ins[15:0], 16'h0};
            6'h04, 6'h05: r = a - b;
            6'h23, 6'h2b: r = a + ims;
            default: r = 32'h0;
        endcase
        return {(r == 32'h0), r[31], ov, r};
    endfunction

    assign {alu_flags, alu_result} = alu_fn(alu_instruction, alu_regA, alu_regB);

    function automatic logic [31:0] rtype(input int rs, input int rt,
                                          input int rd, input logic [5:0] fn);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs,
                                          input int rt, input logic [15:0] imm);
        return {op, rs[4:0], rt[4:0], imm};
    endfunction

    // Which register an instruction targets (-1: none)
    function automatic int dest_of(input logic [31:0] ins);
        int op;
        op = int'(ins[31:26]);
        if (op == 0) return int'(ins[15:11]);
        if (op >= 8 && op <= 14) return int'(ins[20:16]);
        return -1;
    endfunction

    function automatic bit trap_op(input logic [31:0] ins);
        return (ins[31:26] == 6'h08) ||
               (ins[31:26] == 6'h00 && (ins[5:0] == 6'h20 || ins[5:0] == 6'h22));
    endfunction

    // Reference model: execute one instruction on the model register array
    task automatic model_exec(input logic [31:0] ins, output logic [31:0] er,
                              output logic [2:0] ef, output bit et);
        int d;
        {ef, er} = alu_fn(ins, m_regs[ins[25:21]], m_regs[ins[20:16]]);
        et = 1'b0;
`ifdef OVF_TRAP_EN
        et = ef[0] && trap_op(ins);
`endif
        d = dest_of(ins);
        if (d > 0 && !et) m_regs[d] = er;
    endtask

    task automatic host_write(input int a, input logic [31:0] d);
        @(negedge clk);
        host_we    = 1'b1;
        host_waddr = a[4:0];
        host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
        if (a != 0) m_regs[a] = d;
    endtask

    task automatic dbg_read(input int a, output logic [31:0] v);
        dbg_raddr = a[4:0];
        #1;
        v = dbg_rdata;
    endtask

    // Issue one instruction from IDLE and collect what the DUT reports
    task automatic run_instr(input logic [31:0] ins, output int lat,
                             output logic [31:0] res, output logic [2:0] fl,
                             output bit trap, output bit rdy, output bit pulse);
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        #1;
        rdy = instr_ready;
        @(negedge clk);
        instr_valid = 1'b0;
        lat = 1;
        while (done_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        res  = done_result;
        fl   = done_flags;
        trap = 1'b0;
`ifdef OVF_TRAP_EN
        trap = ovf_trap;
`endif
        @(negedge clk);
        pulse = (done_valid === 1'b0);
    endtask

    task automatic test_reset();
        bit seen;
        int bad;
        logic [31:0] v;
        host_write(5, 32'h55);
        host_write(6, 32'h1);
        @(negedge clk);
        instr       = rtype(5, 6, 7, 6'h20);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (done_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done_valid: got %b want 0", done_valid);
        end
        n_tests++;
        if (alu_instruction !== 32'h0 || alu_regA !== 32'h0 || alu_regB !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_alu_outputs: got %h/%h/%h want 0", alu_instruction, alu_regA, alu_regB);
        end
        n_tests++;
        if (done_result !== 32'h0 || done_flags !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_done_data: got %h/%b want 0", done_result, done_flags);
        end
`ifdef OVF_TRAP_EN
        n_tests++;
        if (ovf_trap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf_trap: got %b want 0", ovf_trap);
        end
`endif
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done_valid !== 1'b0) seen = 1'b1;
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after_release: got %b want 1", instr_ready);
        end
        repeat (4) begin
            @(negedge clk);
            if (done_valid !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort_no_done: got done_valid pulse=%b want 0", seen);
        end
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            dbg_read(i, v);
            if (v !== 32'h0) bad++;
            m_regs[i] = 32'h0;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_regfile_zero: got %0d nonzero regs want 0", bad);
        end
    endtask

    task automatic test_add();
        int lat;
        logic [31:0] res, er, v;
        logic [2:0] fl, ef;
        bit trap, et, rdy, pulse;
        host_write(1, 32'd5);
        host_write(2, 32'd7);
        model_exec(rtype(1, 2, 3, 6'h20), er, ef, et);
        run_instr(rtype(1, 2, 3, 6'h20), lat, res, fl, trap, rdy, pulse);
        n_tests++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL add_ready: got %b want 1", rdy);
        end
        n_tests++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL add_latency: got %0d want 3", lat);
        end
        n_tests++;
        if (res !== 32'd12 || fl !== 3'b000) begin
            n_fail++;
            $display("FAIL add_result: got %h/%b want 0000000c/000", res, fl);
        end
        n_tests++;
        if (pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL add_done_single_cycle: got pulse_ok=%b want 1", pulse);
        end
        dbg_read(3, v);
        n_tests++;
        if (v !== 32'd12) begin
            n_fail++;
            $display("FAIL add_writeback: got R3=%h want 0000000c", v);
        end
    endtask

    task automatic test_add_ovf();
        int lat;
        logic [31:0] res, er, v;
        logic [2:0] fl, ef;
        bit trap, et, rdy, pulse;
        host_write(1, 32'h7FFF_FFFF);
        host_write(2, 32'h1);
        host_write(3, 32'h1234);
        model_exec(rtype(1, 2, 3, 6'h20), er, ef, et);
        run_instr(rtype(1, 2, 3, 6'h20), lat, res, fl, trap, rdy, pulse);
        n_tests++;
        if (fl[0] !== 1'b1 || res !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL ovf_flag: got %h/%b want 80000000/xx1", res, fl);
        end
        dbg_read(3, v);
`ifdef OVF_TRAP_EN
        n_tests++;
        if (trap !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_trap_pulse: got %b want 1", trap);
        end
        n_tests++;
        if (v !== 32'h1234) begin
            n_fail++;
            $display("FAIL ovf_trap_suppress: got R3=%h want 00001234", v);
        end
`else
        n_tests++;
        if (v !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL ovf_write: got R3=%h want 80000000", v);
        end
`endif
        model_exec(rtype(1, 2, 3, 6'h21), er, ef, et);
        run_instr(rtype(1, 2, 3, 6'h21), lat, res, fl, trap, rdy, pulse);
        dbg_read(3, v);
        n_tests++;
        if (v !== 32'h8000_0000 || trap !== 1'b0) begin
            n_fail++;
            $display("FAIL addu_no_trap: got R3=%h trap=%b want 80000000/0", v, trap);
        end
    endtask

    task automatic test_addi();
        int lat;
        logic [31:0] res, er, v;
        logic [2:0] fl, ef;
        bit trap, et, rdy, pulse;
        host_write(1, 32'd10);
        model_exec(itype(6'h08, 1, 4, 16'hFFFF), er, ef, et);
        run_instr(itype(6'h08, 1, 4, 16'hFFFF), lat, res, fl, trap, rdy, pulse);
        dbg_read(4, v);
        n_tests++;
        if (v !== 32'd9 || res !== 32'd9 || fl !== 3'b000) begin
            n_fail++;
            $display("FAIL addi_rt: got R4=%h res=%h fl=%b want 9/9/000", v, res, fl);
        end
        model_exec(itype(6'h08, 1, 0, 16'h0005), er, ef, et);
        run_instr(itype(6'h08, 1, 0, 16'h0005), lat, res, fl, trap, rdy, pulse);
        dbg_read(0, v);
        n_tests++;
        if (v !== 32'h0 || res !== 32'd15) begin
            n_fail++;
            $display("FAIL r0_wb_dropped: got R0=%h res=%h want 0/f", v, res);
        end
        host_write(0, 32'hDEAD);
        dbg_read(0, v);
        n_tests++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_host_dropped: got R0=%h want 0", v);
        end
    endtask

    task automatic test_branch_store();
        int lat, bad;
        logic [31:0] res, er, v;
        logic [2:0] fl, ef;
        bit trap, et, rdy, pulse;
        host_write(1, 32'd10);
        host_write(2, 32'd10);
        host_write(3, 32'h3333);
        model_exec(itype(6'h04, 1, 2, 16'h1800), er, ef, et);
        run_instr(itype(6'h04, 1, 2, 16'h1800), lat, res, fl, trap, rdy, pulse);
        n_tests++;
        if (fl[2] !== 1'b1 || lat != 3) begin
            n_fail++;
            $display("FAIL beq_zero_flag: got fl=%b lat=%0d want 1xx/3", fl, lat);
        end
        model_exec(itype(6'h2b, 1, 2, 16'h1808), er, ef, et);
        run_instr(itype(6'h2b, 1, 2, 16'h1808), lat, res, fl, trap, rdy, pulse);
        n_tests++;
        if (res !== 32'h1812) begin
            n_fail++;
            $display("FAIL sw_result: got %h want 00001812", res);
        end
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            dbg_read(i, v);
            if (v !== m_regs[i]) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL nowrite_regs_unchanged: got %0d differing regs want 0", bad);
        end
    endtask

    // Hold instr_valid across two instructions and record accept cycles
    task automatic b2b(input bit use_host, output int d, output bit rdy_drop);
        int acc [2];
        int nacc;
        logic [31:0] ia, ib;
        ia = rtype(1, 2, 5, 6'h20);
        ib = rtype(5, 1, 6, 6'h22);
        acc[0] = 0;
        acc[1] = 0;
        nacc = 0;
        rdy_drop = 1'b0;
        for (int c = 0; c < 30 && nacc < 2; c++) begin
            @(negedge clk);
            host_we    = 1'b0;
            host_waddr = use_host ? 5'd10 : 5'd11;
            host_wdata = use_host ? 32'hCAFE : 32'hBAD;
            if (nacc == 1 && c == acc[0] + (use_host ? 4 : 2)) host_we = 1'b1;
            instr       = (nacc == 0) ? ia : ib;
            instr_valid = 1'b1;
            #1;
            if (host_we && !instr_ready) rdy_drop = 1'b1;
            if (instr_ready) begin
                acc[nacc] = c;
                nacc++;
            end
        end
        @(negedge clk);
        host_we     = 1'b0;
        instr_valid = 1'b0;
        repeat (5) @(negedge clk);
        d = (nacc == 2) ? acc[1] - acc[0] : -1;
    endtask

    task automatic test_back_to_back();
        int d;
        bit drop, et;
        logic [31:0] v, er;
        logic [2:0] ef;
        host_write(1, 32'd10);
        host_write(2, 32'd10);
        host_write(11, 32'h0);
        model_exec(rtype(1, 2, 5, 6'h20), er, ef, et);
        model_exec(rtype(5, 1, 6, 6'h22), er, ef, et);
        b2b(1'b0, d, drop);
        n_tests++;
        if (d != 4) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d want 4", d);
        end
        dbg_read(5, v);
        n_tests++;
        if (v !== 32'd20) begin
            n_fail++;
            $display("FAIL b2b_first_wb: got R5=%h want 00000014", v);
        end
        dbg_read(6, v);
        n_tests++;
        if (v !== 32'd10) begin
            n_fail++;
            $display("FAIL b2b_dependent_wb: got R6=%h want 0000000a", v);
        end
        dbg_read(11, v);
        n_tests++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL host_we_ignored_busy: got R11=%h want 0", v);
        end
        model_exec(rtype(1, 2, 5, 6'h20), er, ef, et);
        model_exec(rtype(5, 1, 6, 6'h22), er, ef, et);
        m_regs[10] = 32'hCAFE;
        b2b(1'b1, d, drop);
        n_tests++;
        if (d != 5 || drop !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_host_priority: got spacing=%0d ready_drop=%b want 5/1", d, drop);
        end
        dbg_read(10, v);
        n_tests++;
        if (v !== 32'hCAFE) begin
            n_fail++;
            $display("FAIL b2b_host_write: got R10=%h want 0000cafe", v);
        end
    endtask

    task automatic test_random();
        logic [5:0] fns [10];
        logic [5:0] ops [12];
        int lat, d, bad;
        logic [31:0] ins, res, er, v;
        logic [2:0] fl, ef;
        bit trap, et, rdy, pulse;
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
        ops = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h04, 6'h05, 6'h23, 6'h2b, 6'h0f};
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                host_write($urandom_range(1, 31),
                           ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 8));
            end
            if ($urandom_range(0, 1) == 0)
                ins = rtype($urandom_range(0, 31), $urandom_range(0, 31),
                            $urandom_range(0, 31), fns[$urandom_range(0, 9)]);
            else
                ins = itype(ops[$urandom_range(0, 11)], $urandom_range(0, 31),
                            $urandom_range(0, 31), 16'($urandom));
            model_exec(ins, er, ef, et);
            run_instr(ins, lat, res, fl, trap, rdy, pulse);
            n_tests++;
            if (lat != 3 || res !== er || fl !== ef || trap !== et) begin
                n_fail++;
                $display("FAIL rand_%0d: ins=%h got lat=%0d res=%h fl=%b trap=%b want 3/%h/%b/%b",
                         it, ins, lat, res, fl, trap, er, ef, et);
            end
            d = dest_of(ins);
            if (d >= 0) begin
                dbg_read(d, v);
                n_tests++;
                if (v !== m_regs[d]) begin
                    n_fail++;
                    $display("FAIL rand_wb_%0d: got R%0d=%h want %h", it, d, v, m_regs[d]);
                end
            end
        end
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            dbg_read(i, v);
            if (v !== m_regs[i]) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rand_final_regs: got %0d differing regs want 0", bad);
        end
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'h0;
        host_we     = 1'b0;
        host_waddr  = 5'h0;
        host_wdata  = 32'h0;
        dbg_raddr   = 5'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_add();
        test_add_ovf();
        test_addi();
        test_branch_store();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
